bcd_sat_converter: RTL and testbench

//  Sequential, parametrised binary-to-BCD converter with saturation to all-nines.

---
 rtl/bcd_sat_converter_pkg.sv | 31 +++
 rtl/bcd_add3.sv | 11 +
 rtl/bcd_sat_converter.sv | 110 +++++++++++
 tb/tb_bcd_sat_converter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/bcd_sat_converter_pkg.sv
// Shared constants and constant functions for the saturating binary-to-BCD converter.
package bcd_sat_converter_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_CONV = 1'b1;

  localparam logic [3:0] BCD_NINE        = 4'h9;
  localparam logic [3:0] BCD_ADD3_THRESH = 4'd5;

  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  // Bits needed to hold values 0 .. v-1.
  function automatic int unsigned clog2(input logic [63:0] v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 64; i++) begin
      if ((64'd1 << i) < v) r = 32'(i + 1);
    end
    return r;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit corrector: adds 3 to a BCD digit of 5 or more before the shift.
module bcd_add3
  import bcd_sat_converter_pkg::*;
(
  input  logic [3:0] d,
  output logic [3:0] q_c
);

  assign q_c = (d >= BCD_ADD3_THRESH) ? d + 4'd3 : d;

endmodule

// File: rtl/bcd_sat_converter.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one bit per clock,
// saturating to all nines when the operand exceeds 10^DIGITS-1.
module bcd_sat_converter
  import bcd_sat_converter_pkg::*;
#(
  parameter int unsigned BIN_W  = 16,
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int unsigned ACC_W = 4 * DIGITS;
  localparam logic [63:0] MAX   = pow10(DIGITS) - 64'd1;
  localparam int unsigned CMP_W = max_u(BIN_W, clog2(MAX + 64'd1));
  localparam int unsigned CNT_W = clog2(64'(BIN_W + 1));
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);
  localparam logic [ACC_W-1:0] NINES = {DIGITS{BCD_NINE}};

  logic [0:0]       state, state_d;
  logic [BIN_W-1:0] sh, sh_d;
  logic [ACC_W-1:0] acc, acc_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             ovf_q, ovf_d;
  logic             busy_d, done_d, overflow_d;
  logic [ACC_W-1:0] bcd_d;

  logic [ACC_W-1:0] acc_corr_c;
  logic [ACC_W-1:0] acc_shift_c;
  logic [BIN_W-1:0] sh_shift_c;
  logic             bin_ovf_c;

  // Widened compare so MAX never truncates against a narrow operand.
  assign bin_ovf_c = CMP_W'(bin) > CMP_W'(MAX);

  for (genvar i = 0; i < DIGITS; i++) begin : g_add3
    bcd_add3 u_add3 (
      .d   (acc[4*i +: 4]),
      .q_c (acc_corr_c[4*i +: 4])
    );
  end

  // Corrected accumulator and shift reg move left as one unit; top-digit carry is dropped.
  assign acc_shift_c = ACC_W'({acc_corr_c, sh[BIN_W-1]});
  assign sh_shift_c  = sh << 1;

  always_comb begin
    state_d    = state;
    sh_d       = sh;
    acc_d      = acc;
    cnt_d      = cnt;
    ovf_d      = ovf_q;
    busy_d     = busy;
    done_d     = 1'b0;
    overflow_d = overflow;
    bcd_d      = bcd;
    if (state == ST_IDLE) begin
      if (start) begin
        sh_d    = bin;
        acc_d   = '0;
        cnt_d   = '0;
        ovf_d   = bin_ovf_c;
        busy_d  = 1'b1;
        state_d = ST_CONV;
      end
    end else begin
      sh_d  = sh_shift_c;
      acc_d = acc_shift_c;
      cnt_d = cnt + CNT_W'(1);
      if (cnt == LAST) begin
        bcd_d      = ovf_q ? NINES : acc_shift_c;
        overflow_d = ovf_q;
        done_d     = 1'b1;
        busy_d     = 1'b0;
        state_d    = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      sh       <= '0;
      acc      <= '0;
      cnt      <= '0;
      ovf_q    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      bcd      <= '0;
    end else begin
      state    <= state_d;
      sh       <= sh_d;
      acc      <= acc_d;
      cnt      <= cnt_d;
      ovf_q    <= ovf_d;
      busy     <= busy_d;
      done     <= done_d;
      overflow <= overflow_d;
      bcd      <= bcd_d;
    end
  end

endmodule

// File: tb/tb_bcd_sat_converter.sv
// Bench for bcd_sat_converter: cycle model per instance plus directed literal checks.
module tb_bcd_sat_converter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [15:0] bin_a = '0;
  logic [7:0]  bin_b = '0;
  logic        busy_a, done_a, overflow_a;
  logic [15:0] bcd_a;
  logic        busy_b, done_b, overflow_b;
  logic [7:0]  bcd_b;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  bcd_sat_converter #(.BIN_W(16), .DIGITS(4)) u_dut_a (
    .clk(clk), .reset(reset), .start(start_a), .bin(bin_a),
    .busy(busy_a), .done(done_a), .overflow(overflow_a), .bcd(bcd_a)
  );

  bcd_sat_converter #(.BIN_W(8), .DIGITS(2)) u_dut_b (
    .clk(clk), .reset(reset), .start(start_b), .bin(bin_b),
    .busy(busy_b), .done(done_b), .overflow(overflow_b), .bcd(bcd_b)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Decimal digits of v, or all nines when v exceeds 10^digits-1.
  function automatic logic [15:0] ref_bcd(input int unsigned v, input int unsigned digits);
    int unsigned mx, x;
    logic [15:0] r;
    mx = 1;
    r  = '0;
    x  = v;
    for (int unsigned i = 0; i < digits; i++) mx = mx * 10;
    mx = mx - 1;
    for (int unsigned i = 0; i < digits; i++) begin
      if (v > mx) r[4*i +: 4] = 4'h9;
      else begin
        r[4*i +: 4] = 4'(x % 10);
        x = x / 10;
      end
    end
    return r;
  endfunction

  // Transaction-level model: accept when idle, report the result BIN_W edges later.
  logic        ma_busy = 0, ma_done = 0, ma_ovf = 0;
  logic [15:0] ma_bcd = '0, ma_op = '0;
  int          ma_left = 0;
  logic        mb_busy = 0, mb_done = 0, mb_ovf = 0;
  logic [7:0]  mb_bcd = '0, mb_op = '0;
  int          mb_left = 0;

  always @(posedge clk) begin
    ma_done <= 1'b0;
    if (reset) begin
      ma_busy <= 1'b0; ma_left <= 0; ma_bcd <= '0; ma_ovf <= 1'b0;
    end else if (!ma_busy) begin
      if (start_a) begin ma_busy <= 1'b1; ma_left <= 16; ma_op <= bin_a; end
    end else begin
      if (ma_left == 1) begin
        ma_busy <= 1'b0; ma_done <= 1'b1;
        ma_bcd  <= ref_bcd(32'(ma_op), 4);
        ma_ovf  <= (32'(ma_op) > 9999);
      end
      ma_left <= ma_left - 1;
    end
  end

  always @(posedge clk) begin
    mb_done <= 1'b0;
    if (reset) begin
      mb_busy <= 1'b0; mb_left <= 0; mb_bcd <= '0; mb_ovf <= 1'b0;
    end else if (!mb_busy) begin
      if (start_b) begin mb_busy <= 1'b1; mb_left <= 8; mb_op <= bin_b; end
    end else begin
      if (mb_left == 1) begin
        mb_busy <= 1'b0; mb_done <= 1'b1;
        mb_bcd  <= 8'(ref_bcd(32'(mb_op), 2));
        mb_ovf  <= (32'(mb_op) > 99);
      end
      mb_left <= mb_left - 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("a_busy", 64'(busy_a), 64'(ma_busy));
      check("a_done", 64'(done_a), 64'(ma_done));
      check("a_bcd", 64'(bcd_a), 64'(ma_bcd));
      check("a_ovf", 64'(overflow_a), 64'(ma_ovf));
      check("b_busy", 64'(busy_b), 64'(mb_busy));
      check("b_done", 64'(done_b), 64'(mb_done));
      check("b_bcd", 64'(bcd_b), 64'(mb_bcd));
      check("b_ovf", 64'(overflow_b), 64'(mb_ovf));
    end
  end

  function automatic logic sel_done(input bit sel_b);
    return sel_b ? done_b : done_a;
  endfunction

  // Advance edges until done is seen (bounded); n counts edges taken in total.
  task automatic wait_done(input bit sel_b, input int n0, output int n);
    n = n0;
    while (!sel_done(sel_b) && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic conv(input bit sel_b, input logic [15:0] v, input logic [15:0] exp_bcd,
                      input logic exp_ovf, input string name);
    int n, bc, lat;
    lat = sel_b ? 8 : 16;
    if (sel_b) begin start_b = 1'b1; bin_b = v[7:0]; end
    else begin start_a = 1'b1; bin_a = v; end
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
    bc = (sel_b ? busy_b : busy_a) ? 1 : 0;
    n = 0;
    while (!sel_done(sel_b) && n < 60) begin
      @(posedge clk); #1;
      n++;
      if (sel_b ? busy_b : busy_a) bc++;
    end
    check({name, "_latency"}, 64'(n), 64'(lat));
    check({name, "_busy_cycles"}, 64'(bc), 64'(lat));
    check({name, "_bcd"}, 64'(sel_b ? {8'h00, bcd_b} : bcd_a), 64'(exp_bcd));
    check({name, "_ovf"}, 64'(sel_b ? overflow_b : overflow_a), 64'(exp_ovf));
  endtask

  initial begin
    int n, dn;
    logic [15:0] rv;
    @(posedge clk); #1;
    chk_en = 1'b1;
    check("reset_busy", 64'(busy_a), 64'd0);
    check("reset_done", 64'(done_a), 64'd0);
    check("reset_bcd", 64'(bcd_a), 64'd0);
    check("reset_ovf", 64'(overflow_a), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    conv(1'b0, 16'd1234, 16'h1234, 1'b0, "t1_1234");
    conv(1'b0, 16'd9999, 16'h9999, 1'b0, "t2_9999");
    conv(1'b0, 16'd10000, 16'h9999, 1'b1, "t2_10000");
    conv(1'b0, 16'd65535, 16'h9999, 1'b1, "t2_65535");
    conv(1'b0, 16'd0, 16'h0000, 1'b0, "t3_zero");
    conv(1'b0, 16'd5, 16'h0005, 1'b0, "t3_five");

    // Start while busy is ignored, then restart in the done cycle.
    start_a = 1'b1; bin_a = 16'd42;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    start_a = 1'b1; bin_a = 16'd777;
    @(posedge clk); #1;
    start_a = 1'b0;
    wait_done(1'b0, 5, n);
    check("t4_first_latency", 64'(n), 64'd16);
    check("t4_first_bcd", 64'(bcd_a), 64'h0042);
    start_a = 1'b1; bin_a = 16'd777;
    @(posedge clk); #1;
    start_a = 1'b0;
    wait_done(1'b0, 1, n);
    check("t4_b2b_spacing", 64'(n), 64'd17);
    check("t4_b2b_bcd", 64'(bcd_a), 64'h0777);
    check("t4_b2b_ovf", 64'(overflow_a), 64'd0);

    // Reset mid-conversion aborts without a done pulse.
    start_a = 1'b1; bin_a = 16'd5555;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("t5_busy", 64'(busy_a), 64'd0);
    check("t5_done", 64'(done_a), 64'd0);
    check("t5_bcd", 64'(bcd_a), 64'd0);
    check("t5_ovf", 64'(overflow_a), 64'd0);
    dn = 0;
    repeat (20) begin @(posedge clk); #1; if (done_a) dn++; end
    check("t5_no_done", 64'(dn), 64'd0);
    conv(1'b0, 16'd5555, 16'h5555, 1'b0, "t5_after");

    conv(1'b1, 16'd255, 16'h0099, 1'b1, "t6_255");
    conv(1'b1, 16'd99, 16'h0099, 1'b0, "t6_99");
    conv(1'b1, 16'd100, 16'h0099, 1'b1, "t6_100");
    conv(1'b1, 16'd57, 16'h0057, 1'b0, "t6_57");

    for (int i = 0; i < 12; i++) begin
      rv = 16'($urandom_range(0, 65535));
      conv(1'b0, rv, ref_bcd(32'(rv), 4), (32'(rv) > 9999), "rand");
    end

    repeat (3) begin @(posedge clk); #1; end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
